// File: rtl/rgb565_gray_stream_pkg.sv
// Shared pixel types, luma coefficients and the RGB565 channel expansion helper
// used by the grayscale conversion pipeline.
package rgb565_gray_stream_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // BT.601-style luma weights scaled by 256; they sum to 256 so white maps to 255
    localparam logic [15:0] LUMA_CR  = 16'd77;
    localparam logic [15:0] LUMA_CG  = 16'd150;
    localparam logic [15:0] LUMA_CB  = 16'd29;
    localparam logic [15:0] LUMA_RND = 16'd128;

    // Replicate the channel MSBs into the new LSBs so full scale maps to 8'hFF
    function automatic rgb888_t expand565(input rgb565_t p);
        rgb888_t e;
        e.r = {p.r, p.r[4:2]};
        e.g = {p.g, p.g[5:4]};
        e.b = {p.b, p.b[4:2]};
        return e;
    endfunction

endpackage

// File: rtl/rgb565_gray_stream_if.sv
// Pixel stream bundle: RGB565 input side (x_*), tagged grayscale output side (y_*)
// and the per-frame status pulses. The converter uses the slave view.
interface rgb565_gray_stream_if #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int W          = 8
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic             x_valid;
    logic             x_ready;
    logic [15:0]      x_data;
    logic             x_sof;
    logic             y_valid;
    logic             y_ready;
    logic [W-1:0]     y_data;
    logic             y_sof;
    logic             y_eol;
    logic [COL_W-1:0] y_col;
    logic [ROW_W-1:0] y_row;
    logic             frame_done;
    logic             frame_err;

    modport slave (
        input  x_valid, x_data, x_sof, y_ready,
        output x_ready, y_valid, y_data, y_sof, y_eol, y_col, y_row, frame_done, frame_err
    );

    modport master (
        output x_valid, x_data, x_sof, y_ready,
        input  x_ready, y_valid, y_data, y_sof, y_eol, y_col, y_row, frame_done, frame_err
    );
endinterface

// File: rtl/rgb565_gray_stream_luma_mac.sv
// Combinational front of the luma datapath: widen each RGB565 channel to 8 bits
// and form the three weighted products that stage 1 registers.
module luma_mac
    import rgb565_gray_stream_pkg::*;
(
    input  rgb565_t     pix,
    output logic [15:0] p_r,
    output logic [15:0] p_g,
    output logic [15:0] p_b
);
    rgb888_t e_s;

    // Expand channels and multiply; each product fits in 16 bits (max 150*255)
    always_comb begin
        e_s = expand565(pix);
        p_r = LUMA_CR * {8'h00, e_s.r};
        p_g = LUMA_CG * {8'h00, e_s.g};
        p_b = LUMA_CB * {8'h00, e_s.b};
    end
endmodule

// File: rtl/rgb565_gray_stream.sv
// RGB565 -> 8-bit grayscale stream converter. Two pipeline stages share one
// global enable so a stalled output freezes the whole pipe; output beats are
// tagged with raster position, start-of-frame and end-of-line, and frame
// completion / truncation are reported as single-cycle pulses.
module rgb565_gray_stream
    import rgb565_gray_stream_pkg::*;
#(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int W          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rgb565_gray_stream_if.slave  bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    if (W != 8) begin : g_w_check
        $error("rgb565_gray_stream: W must be 8");
    end

    logic             en_s;
    logic [15:0]      pr_s, pg_s, pb_s;
    logic [16:0]      sum_s;
    logic [W-1:0]     gray_s;

    logic             s1_valid_r, s1_sof_r;
    logic [15:0]      s1_pr_r, s1_pg_r, s1_pb_r;
    logic             y_valid_r, y_sof_r;
    logic [W-1:0]     y_data_r;

    logic [COL_W-1:0] col_r, tag_col_s;
    logic [ROW_W-1:0] row_r, tag_row_s;
    logic             at_origin_s, col_last_s, row_last_s, fire_s;
    logic             frame_done_r, frame_err_r;

    luma_mac u_mac (
        .pix (rgb565_t'(bus.x_data)),
        .p_r (pr_s),
        .p_g (pg_s),
        .p_b (pb_s)
    );

    // Global enable: the pipe moves whenever the output slot is empty or draining
    always_comb begin
        en_s  = !y_valid_r || bus.y_ready;
        sum_s = {1'b0, s1_pr_r} + {1'b0, s1_pg_r} + {1'b0, s1_pb_r} + {1'b0, LUMA_RND};
        gray_s = W'(sum_s >> 5'd8);
    end

    // Pipeline stages: stage 1 holds products, stage 2 holds the rounded luma
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sof_r   <= 1'b0;
            s1_pr_r    <= 16'd0;
            s1_pg_r    <= 16'd0;
            s1_pb_r    <= 16'd0;
            y_valid_r  <= 1'b0;
            y_sof_r    <= 1'b0;
            y_data_r   <= {W{1'b0}};
        end else if (en_s) begin
            s1_valid_r <= bus.x_valid;
            s1_sof_r   <= bus.x_valid && bus.x_sof;
            s1_pr_r    <= pr_s;
            s1_pg_r    <= pg_s;
            s1_pb_r    <= pb_s;
            y_valid_r  <= s1_valid_r;
            y_sof_r    <= s1_valid_r && s1_sof_r;
            y_data_r   <= gray_s;
        end
    end

    // Position of the beat on the output: an explicit sof re-tags it as (0,0)
    always_comb begin
        at_origin_s = (col_r == {COL_W{1'b0}}) && (row_r == {ROW_W{1'b0}});
        if (y_sof_r) begin
            tag_col_s = {COL_W{1'b0}};
            tag_row_s = {ROW_W{1'b0}};
        end else begin
            tag_col_s = col_r;
            tag_row_s = row_r;
        end
        col_last_s = (tag_col_s == COL_LAST);
        row_last_s = (tag_row_s == ROW_LAST);
        fire_s     = y_valid_r && bus.y_ready;
    end

    // Raster counters and frame status pulses, advanced per delivered beat
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r        <= {COL_W{1'b0}};
            row_r        <= {ROW_W{1'b0}};
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (fire_s) begin
                frame_err_r <= y_sof_r && !at_origin_s;
                if (col_last_s) begin
                    col_r <= {COL_W{1'b0}};
                    if (row_last_s) begin
                        row_r        <= {ROW_W{1'b0}};
                        frame_done_r <= 1'b1;
                    end else begin
                        row_r <= tag_row_s + ROW_W'(1'b1);
                    end
                end else begin
                    col_r <= tag_col_s + COL_W'(1'b1);
                    row_r <= tag_row_s;
                end
            end
        end
    end

    assign bus.x_ready    = en_s;
    assign bus.y_valid    = y_valid_r;
    assign bus.y_data     = y_data_r;
    assign bus.y_sof      = y_valid_r && (y_sof_r || at_origin_s);
    assign bus.y_eol      = col_last_s;
    assign bus.y_col      = tag_col_s;
    assign bus.y_row      = tag_row_s;
    assign bus.frame_done = frame_done_r;
    assign bus.frame_err  = frame_err_r;
endmodule

// File: tb/tb_rgb565_gray_stream.sv
// Self-checking bench for rgb565_gray_stream, built with a reduced 120x6 raster so
// that full frames stay short. A negedge monitor keeps a scoreboard of expected
// gray values (pushed at input acceptance) and an independent position model.
module tb_rgb565_gray_stream;
    localparam int TW = 120;
    localparam int TH = 6;

    typedef struct {
        logic [7:0] gray;
        logic       sof;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb565_gray_stream_if #(.IMG_WIDTH(TW), .IMG_HEIGHT(TH), .W(8)) bus ();

    rgb565_gray_stream #(.IMG_WIDTH(TW), .IMG_HEIGHT(TH), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int negc = 0;
    int rmode = 0;
    int stall_start = 0;
    int mcol = 0, mrow = 0;
    int n_sof = 0, n_eol = 0, n_done = 0, n_err = 0;
    bit exp_done = 1'b0, exp_err = 1'b0;
    bit lat_chk = 1'b0;
    bit hold_prev = 1'b0;
    logic [7:0] hold_data;
    int hold_col, hold_row;
    logic hold_sof;
    exp_t sb_q[$];
    logic [7:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_gray(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]); r = (r << 3) | (r >> 2);
        g = int'(p[10:5]);  g = (g << 2) | (g >> 4);
        b = int'(p[4:0]);   b = (b << 3) | (b >> 2);
        return 8'((77 * r + 150 * g + 29 * b + 128) / 256);
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: pulses, handshake rule, stall stability, scoreboard and tags
    always @(negedge clk) begin
        exp_t e;
        int ecol, erow;
        negc++;
        if (rst) begin
            sb_q.delete();
            mcol = 0; mrow = 0;
            exp_done = 1'b0; exp_err = 1'b0;
            hold_prev = 1'b0;
        end else begin
            check("frame_done", bus.frame_done, exp_done);
            check("frame_err", bus.frame_err, exp_err);
            if (bus.frame_done) n_done++;
            if (bus.frame_err) n_err++;
            exp_done = 1'b0; exp_err = 1'b0;
            check("x_ready", bus.x_ready, !bus.y_valid || bus.y_ready);
            if (hold_prev) begin
                check("stall_valid", bus.y_valid, 1);
                check("stall_data", bus.y_data, hold_data);
                check("stall_col", bus.y_col, hold_col);
                check("stall_row", bus.y_row, hold_row);
                check("stall_sof", bus.y_sof, hold_sof);
            end
            if (bus.y_valid && bus.y_ready) begin
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    got_q.push_back(bus.y_data);
                    ecol = e.sof ? 0 : mcol;
                    erow = e.sof ? 0 : mrow;
                    check("y_data", bus.y_data, e.gray);
                    check("y_sof", bus.y_sof, e.sof || (mcol == 0 && mrow == 0));
                    check("y_col", bus.y_col, ecol);
                    check("y_row", bus.y_row, erow);
                    check("y_eol", bus.y_eol, ecol == TW - 1);
                    if (lat_chk) check("latency", negc - e.acc, 2);
                    if (bus.y_sof) n_sof++;
                    if (bus.y_eol) n_eol++;
                    exp_err = e.sof && (mcol != 0 || mrow != 0);
                    if (ecol == TW - 1) begin
                        mcol = 0;
                        if (erow == TH - 1) begin
                            mrow = 0;
                            exp_done = 1'b1;
                        end else begin
                            mrow = erow + 1;
                        end
                    end else begin
                        mcol = ecol + 1;
                        mrow = erow;
                    end
                end
            end
            hold_prev = bus.y_valid && !bus.y_ready;
            hold_data = bus.y_data;
            hold_col  = int'(bus.y_col);
            hold_row  = int'(bus.y_row);
            hold_sof  = bus.y_sof;
            if (bus.x_valid && bus.x_ready) begin
                e.gray = ref_gray(bus.x_data);
                e.sof  = bus.x_sof;
                e.acc  = negc;
                sb_q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rmode)
            0: bus.y_ready = 1'b1;
            1: bus.y_ready = ($urandom_range(0, 2) != 0);
            default: bus.y_ready = !((cyc >= stall_start) && (cyc < stall_start + 5));
        endcase
    endtask

    task automatic send(input logic [15:0] d, input logic s);
        int t;
        bit acc;
        bus.x_valid = 1'b1;
        bus.x_data  = d;
        bus.x_sof   = s;
        t = 0;
        acc = 1'b0;
        while (!acc && t <= 200) begin
            @(negedge clk);
            if (bus.x_ready) acc = 1'b1;
            else t++;
            tick();
        end
        if (!acc) check("send_timeout", t, 0);
        bus.x_valid = 1'b0;
        bus.x_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        logic [7:0] exp5 [5];
        logic [15:0] pix5 [5];
        int d0, e0;
        exp5 = '{8'd255, 8'd0, 8'd77, 8'd149, 8'd29};
        pix5 = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'h001F};
        bus.x_valid = 1'b0; bus.x_data = 16'h0000; bus.x_sof = 1'b0; bus.y_ready = 1'b1;

        // reset state
        idle(3);
        @(negedge clk);
        check("rst_y_valid", bus.y_valid, 0);
        check("rst_y_data", bus.y_data, 0);
        check("rst_y_sof", bus.y_sof, 0);
        check("rst_y_eol", bus.y_eol, 0);
        check("rst_col", bus.y_col, 0);
        check("rst_row", bus.y_row, 0);
        check("rst_done", bus.frame_done, 0);
        check("rst_err", bus.frame_err, 0);
        tick();
        rst = 1'b0;
        idle(2);

        // primaries back-to-back with latency check
        got_q.delete();
        lat_chk = 1'b1;
        for (int i = 0; i < 5; i++) send(pix5[i], 1'b0);
        idle(4);
        lat_chk = 1'b0;
        check("t1_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) check("t1_gray", (got_q.size() > i) ? got_q[i] : 8'hxx, exp5[i]);

        // 20-pixel stream with a 5-cycle output stall
        got_q.delete();
        rmode = 2;
        stall_start = cyc + 8;
        for (int i = 0; i < 20; i++) send(16'(i * 16'h0C35 + 16'h1234), 1'b0);
        idle(14);
        rmode = 0;
        idle(2);
        check("t2_count", got_q.size(), 20);

        // clean restart before the full frame
        rst = 1'b1; tick(); rst = 1'b0; idle(2);

        // full frame with explicit sof
        n_sof = 0; n_eol = 0; n_done = 0; n_err = 0;
        for (int p = 0; p < TW * TH; p++) send(16'($urandom), p == 0);
        idle(5);
        check("t3_sof_count", n_sof, 1);
        check("t3_eol_count", n_eol, TH);
        check("t3_done_count", n_done, 1);
        check("t3_err_count", n_err, 0);

        // sof reasserted at (100,3) truncates the frame
        d0 = n_done; e0 = n_err;
        for (int p = 0; p < 3 * TW + 100; p++) send(16'($urandom), 1'b0);
        send(16'hA5A5, 1'b1);
        idle(4);
        check("t4_err_pulses", n_err - e0, 1);
        check("t4_done_pulses", n_done - d0, 0);

        // reset with two pixels in flight mid-frame
        for (int p = 0; p < 3; p++) send(16'($urandom), 1'b0);
        send(16'h1357, 1'b0);
        send(16'h2468, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_y_valid", bus.y_valid, 0);
        check("t5_col", bus.y_col, 0);
        check("t5_row", bus.y_row, 0);
        check("t5_done", bus.frame_done, 0);
        check("t5_err", bus.frame_err, 0);
        tick();

        // two frames with random valid/ready; the first starts on implicit sof
        d0 = n_done; e0 = n_err;
        rmode = 1;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < TW * TH; p++) begin
                if ($urandom_range(0, 2) == 0) idle(1);
                send(16'($urandom), (f == 1) && (p == 0));
            end
        end
        rmode = 0;
        idle(6);
        check("t6_done_pulses", n_done - d0, 2);
        check("t6_err_pulses", n_err - e0, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
